// File: rtl/sp_io_pkg.sv
// Shared definitions for the stub-processing programming-bus controller.
package sp_io_pkg;

   localparam int unsigned DATA_W     = 32;
   localparam int unsigned ADDR_W     = 20;
   localparam int unsigned SLV_ADDR_W = 16;
   localparam int unsigned CODE_W     = 4;
   localparam int unsigned ERR_CNT_W  = 16;

   // Function-block codes carried in io_addr[19:16]
   localparam logic [CODE_W-1:0] FC_STUB_TAG     = 4'h2;
   localparam logic [CODE_W-1:0] FC_TRKLT_SEARCH = 4'h4;
   localparam logic [CODE_W-1:0] FC_TRK_PARAM    = 4'h5;

   localparam logic [DATA_W-1:0] ERR_WORD_DEFAULT = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Request fields forwarded to the selected slave
   typedef struct packed {
      logic [SLV_ADDR_W-1:0] addr;
      logic                  rd_en;
      logic                  wr_en;
      logic [DATA_W-1:0]     wr_data;
   } io_req_t;

   // Function-block code field of a host address
   function automatic logic [CODE_W-1:0] addr_code(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: CODE_W];
   endfunction

endpackage

// File: rtl/sp_io_slave_mux.sv
// One-hot read-data / read-ack selector across the slave slots.
module sp_io_slave_mux
   import sp_io_pkg::*;
#(
   parameter int unsigned NUM_SLAVES = 3
) (
   input  logic [NUM_SLAVES-1:0]        sel,
   input  logic [NUM_SLAVES*DATA_W-1:0] rd_data,
   input  logic [NUM_SLAVES-1:0]        rd_ack,
   output logic [DATA_W-1:0]            rd_data_c,
   output logic                         rd_ack_c
);

   // AND-OR select; unselected slots contribute nothing
   always_comb begin
      rd_data_c = '0;
      rd_ack_c  = 1'b0;
      for (int i = 0; i < int'(NUM_SLAVES); i++) begin
         if (sel[i]) begin
            rd_data_c = rd_data_c | rd_data[DATA_W*i +: DATA_W];
            rd_ack_c  = rd_ack_c | rd_ack[i];
         end
      end
   end

endmodule

// File: rtl/sp_io_bus_ctrl.sv
// Programming-bus sequencer: decodes io_addr[19:16] to a slave slot, issues a
// select/sync pulse, waits for the read ack and returns registered data.
// Optional read-wait timeout enabled by defining SP_IO_TIMEOUT_EN.
module sp_io_bus_ctrl
   import sp_io_pkg::*;
#(
   parameter int unsigned                 NUM_SLAVES     = 3,
   parameter logic [CODE_W*NUM_SLAVES-1:0] SLV_CODES     = {FC_TRK_PARAM, FC_TRKLT_SEARCH, FC_STUB_TAG},
   parameter int unsigned                 TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0]           ERR_WORD       = ERR_WORD_DEFAULT
) (
   input  logic                         io_clk,
   input  logic                         reset,
   input  logic                         io_sel,
   input  logic                         io_sync,
   input  logic [ADDR_W-1:0]            io_addr,
   input  logic                         io_rd_en,
   input  logic                         io_wr_en,
   input  logic [DATA_W-1:0]            io_wr_data,
   output logic [DATA_W-1:0]            io_rd_data,
   output logic                         io_rd_ack,
   output logic                         busy,
   output logic [ERR_CNT_W-1:0]         err_cnt,
   output logic [NUM_SLAVES-1:0]        slv_sel,
   output logic                         slv_sync,
   output logic [SLV_ADDR_W-1:0]        slv_addr,
   output logic                         slv_rd_en,
   output logic                         slv_wr_en,
   output logic [DATA_W-1:0]            slv_wr_data,
   input  logic [NUM_SLAVES*DATA_W-1:0] slv_rd_data,
   input  logic [NUM_SLAVES-1:0]        slv_rd_ack
);

   state_t                state, state_n;
   io_req_t               req_q, req_n;
   logic [NUM_SLAVES-1:0] sel_n;
   logic                  sync_n;
   logic                  rd_ack_n;
   logic [DATA_W-1:0]     rd_data_n;
   logic                  err_inc;
   logic                  hit_c;
   logic [NUM_SLAVES-1:0] hit_oh_c;
   logic [DATA_W-1:0]     mux_data_c;
   logic                  mux_ack_c;

   // Reject a timeout too short to cover the minimum read latency
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
      $error("sp_io_bus_ctrl: TIMEOUT_CYCLES must be at least 2");
   end

`ifdef SP_IO_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
`endif

   assign slv_addr    = req_q.addr;
   assign slv_rd_en   = req_q.rd_en;
   assign slv_wr_en   = req_q.wr_en;
   assign slv_wr_data = req_q.wr_data;

   sp_io_slave_mux #(
      .NUM_SLAVES (NUM_SLAVES)
   ) u_slave_mux (
      .sel       (slv_sel),
      .rd_data   (slv_rd_data),
      .rd_ack    (slv_rd_ack),
      .rd_data_c (mux_data_c),
      .rd_ack_c  (mux_ack_c)
   );

   // Address decode; iterating downward leaves the lowest matching slot
   always_comb begin
      hit_c    = 1'b0;
      hit_oh_c = '0;
      for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
         if (addr_code(io_addr) == SLV_CODES[CODE_W*i +: CODE_W]) begin
            hit_c       = 1'b1;
            hit_oh_c    = '0;
            hit_oh_c[i] = 1'b1;
         end
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      req_n     = req_q;
      sel_n     = slv_sel;
      sync_n    = 1'b0;
      rd_ack_n  = 1'b0;
      rd_data_n = io_rd_data;
      err_inc   = 1'b0;
`ifdef SP_IO_TIMEOUT_EN
      wait_cnt_n = wait_cnt;
`endif
      case (state)
         IDLE: begin
            if (io_sel && io_sync) begin
               if (io_rd_en ^ io_wr_en) begin
                  if (hit_c) begin
                     state_n       = WAIT;
                     sel_n         = hit_oh_c;
                     sync_n        = 1'b1;
                     req_n.addr    = io_addr[SLV_ADDR_W-1:0];
                     req_n.rd_en   = io_rd_en;
                     req_n.wr_en   = io_wr_en;
                     req_n.wr_data = io_wr_data;
`ifdef SP_IO_TIMEOUT_EN
                     wait_cnt_n    = '0;
`endif
                  end else begin
                     err_inc = 1'b1;
                     if (io_rd_en) begin
                        state_n   = RESP;
                        rd_ack_n  = 1'b1;
                        rd_data_n = ERR_WORD;
                     end
                  end
               end else begin
                  err_inc = 1'b1;
               end
            end
         end
         WAIT: begin
            if (req_q.wr_en) begin
               state_n = IDLE;
            end else if (mux_ack_c) begin
               state_n   = RESP;
               rd_ack_n  = 1'b1;
               rd_data_n = mux_data_c;
            end
`ifdef SP_IO_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               state_n   = RESP;
               rd_ack_n  = 1'b1;
               rd_data_n = ERR_WORD;
               err_inc   = 1'b1;
            end else begin
               wait_cnt_n = wait_cnt + CNT_W'(1);
            end
`endif
            // Select and operation strobes live only for the WAIT phase
            if (state_n != WAIT) begin
               sel_n       = '0;
               req_n.rd_en = 1'b0;
               req_n.wr_en = 1'b0;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge io_clk) begin
      if (reset) begin
         state      <= IDLE;
         req_q      <= '0;
         slv_sel    <= '0;
         slv_sync   <= 1'b0;
         io_rd_ack  <= 1'b0;
         io_rd_data <= '0;
         busy       <= 1'b0;
         err_cnt    <= '0;
      end else begin
         state      <= state_n;
         req_q      <= req_n;
         slv_sel    <= sel_n;
         slv_sync   <= sync_n;
         io_rd_ack  <= rd_ack_n;
         io_rd_data <= rd_data_n;
         busy       <= (state_n != IDLE);
         if (err_inc && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
         end
      end
   end

`ifdef SP_IO_TIMEOUT_EN
   // Read-wait cycle counter
   always_ff @(posedge io_clk) begin
      if (reset) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt_n;
      end
   end
`endif

endmodule

// File: tb/tb_sp_io_bus_ctrl.sv
// Self-checking bench for sp_io_bus_ctrl: read responses go through a
// scoreboard queue, control outputs are checked at fixed cycles.
module tb_sp_io_bus_ctrl;
   import sp_io_pkg::*;

   localparam int unsigned NS  = 3;
   localparam int unsigned TMO = 4;

   logic              io_clk = 1'b0;
   logic              reset;
   logic              io_sel, io_sync, io_rd_en, io_wr_en;
   logic [19:0]       io_addr;
   logic [31:0]       io_wr_data;
   logic [31:0]       io_rd_data;
   logic              io_rd_ack, busy;
   logic [15:0]       err_cnt;
   logic [NS-1:0]     slv_sel;
   logic              slv_sync;
   logic [15:0]       slv_addr;
   logic              slv_rd_en, slv_wr_en;
   logic [31:0]       slv_wr_data;
   logic [NS*32-1:0]  slv_rd_data;
   logic [NS-1:0]     slv_rd_ack;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];

   sp_io_bus_ctrl #(
      .NUM_SLAVES     (NS),
      .SLV_CODES      (12'h542),
      .TIMEOUT_CYCLES (TMO),
      .ERR_WORD       (32'hDEAD_BEEF)
   ) dut (
      .io_clk      (io_clk),
      .reset       (reset),
      .io_sel      (io_sel),
      .io_sync     (io_sync),
      .io_addr     (io_addr),
      .io_rd_en    (io_rd_en),
      .io_wr_en    (io_wr_en),
      .io_wr_data  (io_wr_data),
      .io_rd_data  (io_rd_data),
      .io_rd_ack   (io_rd_ack),
      .busy        (busy),
      .err_cnt     (err_cnt),
      .slv_sel     (slv_sel),
      .slv_sync    (slv_sync),
      .slv_addr    (slv_addr),
      .slv_rd_en   (slv_rd_en),
      .slv_wr_en   (slv_wr_en),
      .slv_wr_data (slv_wr_data),
      .slv_rd_data (slv_rd_data),
      .slv_rd_ack  (slv_rd_ack)
   );

   always #5 io_clk = ~io_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge io_clk);
      #1;
   endtask

   // Present one request for a single cycle; returns in cycle 1
   task automatic issue(input logic [19:0] a, input logic rd, input logic wr, input logic [31:0] d);
      io_sel     = 1'b1;
      io_sync    = 1'b1;
      io_addr    = a;
      io_rd_en   = rd;
      io_wr_en   = wr;
      io_wr_data = d;
      tick();
      io_sel   = 1'b0;
      io_sync  = 1'b0;
      io_rd_en = 1'b0;
      io_wr_en = 1'b0;
   endtask

   // Scoreboard monitor: every read ack must match the oldest expectation
   always @(negedge io_clk) begin
      if (io_rd_ack === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_rd_ack", {31'b0, io_rd_ack}, 32'd0);
         else                   chk("rd_data", io_rd_data, exp_q.pop_front());
      end
   end

   initial begin
      reset       = 1'b1;
      io_sel      = 1'b0;
      io_sync     = 1'b0;
      io_rd_en    = 1'b0;
      io_wr_en    = 1'b0;
      io_addr     = '0;
      io_wr_data  = '0;
      slv_rd_data = '0;
      slv_rd_ack  = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_busy",    {31'b0, busy}, 32'd0);
      chk("rst_rd_ack",  {31'b0, io_rd_ack}, 32'd0);
      chk("rst_rd_data", io_rd_data, 32'd0);
      chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
      chk("rst_slv_sel", {29'b0, slv_sel}, 32'd0);

      // Read code 2, slave 0 acks at cycle 3
      issue(20'h2_0010, 1'b1, 1'b0, 32'h0);
      chk("rd_c1_sel",   {29'b0, slv_sel}, 32'd1);
      chk("rd_c1_sync",  {31'b0, slv_sync}, 32'd1);
      chk("rd_c1_rden",  {31'b0, slv_rd_en}, 32'd1);
      chk("rd_c1_addr",  {16'b0, slv_addr}, 32'h0010);
      chk("rd_c1_busy",  {31'b0, busy}, 32'd1);
      tick();
      chk("rd_c2_sync",  {31'b0, slv_sync}, 32'd0);
      chk("rd_c2_ack",   {31'b0, io_rd_ack}, 32'd0);
      tick();
      slv_rd_data[31:0] = 32'h1234_5678;
      slv_rd_ack        = 3'b001;
      exp_q.push_back(32'h1234_5678);
      tick();
      slv_rd_ack = '0;
      chk("rd_c4_ack",   {31'b0, io_rd_ack}, 32'd1);
      tick();
      chk("rd_c5_busy",  {31'b0, busy}, 32'd0);

      // Write hit to code 5
      issue(20'h5_00A0, 1'b0, 1'b1, 32'h0000_CAFE);
      chk("wr_c1_sel",   {29'b0, slv_sel}, 32'b100);
      chk("wr_c1_wren",  {31'b0, slv_wr_en}, 32'd1);
      chk("wr_c1_addr",  {16'b0, slv_addr}, 32'h00A0);
      chk("wr_c1_data",  slv_wr_data, 32'h0000_CAFE);
      tick();
      chk("wr_c2_busy",  {31'b0, busy}, 32'd0);
      chk("wr_c2_sel",   {29'b0, slv_sel}, 32'd0);

      // Read miss to code 7
      exp_q.push_back(32'hDEAD_BEEF);
      issue(20'h7_0000, 1'b1, 1'b0, 32'h0);
      chk("miss_c1_ack", {31'b0, io_rd_ack}, 32'd1);
      chk("miss_err",    {16'b0, err_cnt}, 32'd1);
      tick();
      chk("miss_c2_busy", {31'b0, busy}, 32'd0);

      // Write miss, then malformed operations
      issue(20'h9_0000, 1'b0, 1'b1, 32'h1);
      chk("wmiss_busy",  {31'b0, busy}, 32'd0);
      chk("wmiss_err",   {16'b0, err_cnt}, 32'd2);
      issue(20'h2_0000, 1'b1, 1'b1, 32'h1);
      chk("both_busy",   {31'b0, busy}, 32'd0);
      issue(20'h2_0000, 1'b0, 1'b0, 32'h1);
      chk("bad_op_err",  {16'b0, err_cnt}, 32'd4);

      // Ack from the wrong slot ignored; io_sync while busy ignored
      io_sel   = 1'b1;
      io_sync  = 1'b1;
      io_addr  = 20'h2_0044;
      io_rd_en = 1'b1;
      tick();
      io_rd_en           = 1'b0;
      io_wr_en           = 1'b1;
      io_addr            = 20'h4_0000;
      slv_rd_data[63:32] = 32'h55AA_55AA;
      slv_rd_ack         = 3'b010;
      tick();
      chk("xack_c2_busy", {31'b0, busy}, 32'd1);
      chk("xack_c2_sel",  {29'b0, slv_sel}, 32'd1);
      io_sel            = 1'b0;
      io_sync           = 1'b0;
      io_wr_en          = 1'b0;
      slv_rd_data[31:0] = 32'h0BAD_F00D;
      slv_rd_ack        = 3'b001;
      exp_q.push_back(32'h0BAD_F00D);
      tick();
      slv_rd_ack = '0;
      chk("xack_c3_ack",  {31'b0, io_rd_ack}, 32'd1);
      chk("xack_err",     {16'b0, err_cnt}, 32'd4);
      tick();
      chk("xack_c4_busy", {31'b0, busy}, 32'd0);

      // Minimum-latency read on slot 1, then back-to-back write
      issue(20'h4_0020, 1'b1, 1'b0, 32'h0);
      slv_rd_data[63:32] = 32'hA5A5_0001;
      slv_rd_ack         = 3'b010;
      exp_q.push_back(32'hA5A5_0001);
      tick();
      slv_rd_ack = '0;
      chk("fast_c2_ack",  {31'b0, io_rd_ack}, 32'd1);
      tick();
      issue(20'h5_0030, 1'b0, 1'b1, 32'h1111);
      chk("b2b_sel",      {29'b0, slv_sel}, 32'b100);
      chk("b2b_sync",     {31'b0, slv_sync}, 32'd1);
      tick();

`ifdef SP_IO_TIMEOUT_EN
      // Timeout with no ack, then a late ack is ignored
      issue(20'h2_0000, 1'b1, 1'b0, 32'h0);
      exp_q.push_back(32'hDEAD_BEEF);
      repeat (3) tick();
      chk("tmo_c4_busy",  {31'b0, busy}, 32'd1);
      tick();
      chk("tmo_c5_ack",   {31'b0, io_rd_ack}, 32'd1);
      chk("tmo_err",      {16'b0, err_cnt}, 32'd5);
      tick();
      slv_rd_data[31:0] = 32'h7777_7777;
      slv_rd_ack        = 3'b001;
      tick();
      slv_rd_ack = '0;
      chk("tmo_c7_busy",  {31'b0, busy}, 32'd0);
`else
      // Without a timeout the read waits as long as it takes
      issue(20'h2_0000, 1'b1, 1'b0, 32'h0);
      repeat (10) tick();
      chk("hold_busy",    {31'b0, busy}, 32'd1);
      slv_rd_data[31:0] = 32'h1357_9BDF;
      slv_rd_ack        = 3'b001;
      exp_q.push_back(32'h1357_9BDF);
      tick();
      slv_rd_ack = '0;
      chk("hold_ack",     {31'b0, io_rd_ack}, 32'd1);
      chk("hold_err",     {16'b0, err_cnt}, 32'd4);
      tick();
`endif

      // Reset at cycle 2 of a pending read, ack presented in the same cycle
      issue(20'h2_0010, 1'b1, 1'b0, 32'h0);
      tick();
      reset             = 1'b1;
      slv_rd_data[31:0] = 32'h9999_9999;
      slv_rd_ack        = 3'b001;
      tick();
      reset      = 1'b0;
      slv_rd_ack = '0;
      chk("abort_busy",   {31'b0, busy}, 32'd0);
      chk("abort_ack",    {31'b0, io_rd_ack}, 32'd0);
      chk("abort_sel",    {29'b0, slv_sel}, 32'd0);
      chk("abort_rdata",  io_rd_data, 32'd0);
      chk("abort_addr",   {16'b0, slv_addr}, 32'd0);
      chk("abort_err",    {16'b0, err_cnt}, 32'd0);
      chk("abort_rden",   {31'b0, slv_rd_en}, 32'd0);

      // Next request after reset is accepted normally
      issue(20'h5_0004, 1'b1, 1'b0, 32'h0);
      chk("post_sel",     {29'b0, slv_sel}, 32'b100);
      slv_rd_data[95:64] = 32'hC0FF_EE01;
      slv_rd_ack         = 3'b100;
      exp_q.push_back(32'hC0FF_EE01);
      tick();
      slv_rd_ack = '0;
      chk("post_ack",     {31'b0, io_rd_ack}, 32'd1);
      repeat (3) tick();

      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
